// File: rtl/keycode_action_decoder.sv
`default_nettype none
// ============================================================================
// Module   : keycode_action_decoder
// Brief    : Maps two HID keycode slots to per-player movement levels and
//            frame-paced attack/cooldown sequences for a two-player fighter.
// Revision : 1.0 - initial release
// ============================================================================
module keycode_action_decoder #(
    parameter int ATTACK_FRAMES   = 8,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int CNT_W           = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode_a,
    input  logic [7:0] keycode_b,
    output logic [1:0] move_left,
    output logic [1:0] move_right,
    output logic [1:0] jump,
    output logic [1:0] crouch,
    output logic [1:0] attack_start,
    output logic [1:0] attack_kind,
    output logic [1:0] attacking,
    output logic [1:0] cooldown
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_att_last = CNT_W'(ATTACK_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_cd_last  = CNT_W'(COOLDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [7:0] r_kc_a;
    logic [7:0] r_kc_b;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_kc_a <= 8'h00;
            r_kc_b <= 8'h00;
        end else begin
            r_kc_a <= keycode_a;
            r_kc_b <= keycode_b;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_player
        localparam logic [7:0] c_left   = (p == 0) ? 8'h04 : 8'h50;
        localparam logic [7:0] c_right  = (p == 0) ? 8'h07 : 8'h4F;
        localparam logic [7:0] c_jump   = (p == 0) ? 8'h1A : 8'h52;
        localparam logic [7:0] c_crouch = (p == 0) ? 8'h16 : 8'h51;
        localparam logic [7:0] c_punch  = (p == 0) ? 8'h09 : 8'h0D;
        localparam logic [7:0] c_kick   = (p == 0) ? 8'h0A : 8'h0E;

        logic w_left, w_right, w_jump, w_crouch, w_punch, w_kick;
        logic w_punch_rise, w_kick_rise, w_trig;
        state_t r_state, w_state_nxt;
        logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
        logic r_kind, w_kind_nxt;
        logic r_start, w_start_nxt;
        logic r_prev_punch, r_prev_kick;
        logic r_left, r_right, r_jump, r_crouch;

        assign w_left   = (r_kc_a == c_left)   || (r_kc_b == c_left);
        assign w_right  = (r_kc_a == c_right)  || (r_kc_b == c_right);
        assign w_jump   = (r_kc_a == c_jump)   || (r_kc_b == c_jump);
        assign w_crouch = (r_kc_a == c_crouch) || (r_kc_b == c_crouch);
        assign w_punch  = (r_kc_a == c_punch)  || (r_kc_b == c_punch);
        assign w_kick   = (r_kc_a == c_kick)   || (r_kc_b == c_kick);

        assign w_punch_rise = w_punch & ~r_prev_punch;
        assign w_kick_rise  = w_kick & ~r_prev_kick;
        assign w_trig       = w_punch_rise | w_kick_rise;

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_kind_nxt  = r_kind;
            w_start_nxt = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A tick coinciding with the trigger is deliberately not counted
                    if (w_trig) begin
                        w_state_nxt = ST_ACTIVE;
                        w_cnt_nxt   = '0;
                        w_kind_nxt  = ~w_punch_rise;
                        w_start_nxt = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (frame_tick) begin
                        if (r_cnt == c_att_last) begin
                            w_state_nxt = ST_COOLDOWN;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (frame_tick) begin
                        if (r_cnt == c_cd_last) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_state      <= ST_IDLE;
                r_cnt        <= '0;
                r_kind       <= 1'b0;
                r_start      <= 1'b0;
                r_prev_punch <= 1'b0;
                r_prev_kick  <= 1'b0;
                r_left       <= 1'b0;
                r_right      <= 1'b0;
                r_jump       <= 1'b0;
                r_crouch     <= 1'b0;
            end else begin
                r_state      <= w_state_nxt;
                r_cnt        <= w_cnt_nxt;
                r_kind       <= w_kind_nxt;
                r_start      <= w_start_nxt;
                r_prev_punch <= w_punch;
                r_prev_kick  <= w_kick;
                // Mask against the upcoming state so movement never overlaps attacking
                r_left   <= w_left & ~w_right & (w_state_nxt != ST_ACTIVE);
                r_right  <= w_right & ~w_left & (w_state_nxt != ST_ACTIVE);
                r_jump   <= w_jump & (w_state_nxt != ST_ACTIVE);
                r_crouch <= w_crouch & ~w_jump & (w_state_nxt != ST_ACTIVE);
            end
        end

        assign move_left[p]    = r_left;
        assign move_right[p]   = r_right;
        assign jump[p]         = r_jump;
        assign crouch[p]       = r_crouch;
        assign attack_start[p] = r_start;
        assign attack_kind[p]  = r_kind;
        assign attacking[p]    = (r_state == ST_ACTIVE);
        assign cooldown[p]     = (r_state == ST_COOLDOWN);
    end

endmodule
`default_nettype wire

// File: tb/tb_keycode_action_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_keycode_action_decoder
// Brief    : Directed scoreboard bench for keycode_action_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keycode_action_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [7:0] keycode_a;
    logic [7:0] keycode_b;
    logic [1:0] move_left, move_right, jump, crouch;
    logic [1:0] attack_start, attack_kind, attacking, cooldown;

    int errors = 0;
    int checks = 0;

    // Observed bundle: {ml, mr, jump, crouch, start, kind, attacking, cooldown}
    localparam logic [15:0] M_ALL    = 16'hFFFF;
    localparam logic [15:0] M_NOKIND = 16'hFFCF;

    typedef struct {
        string       tag;
        logic [15:0] mask;
        logic [15:0] exp;
    } sb_t;

    sb_t sb_q[$];

    keycode_action_decoder #(
        .ATTACK_FRAMES  (8),
        .COOLDOWN_FRAMES(4),
        .CNT_W          (6)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .frame_tick  (frame_tick),
        .keycode_a   (keycode_a),
        .keycode_b   (keycode_b),
        .move_left   (move_left),
        .move_right  (move_right),
        .jump        (jump),
        .crouch      (crouch),
        .attack_start(attack_start),
        .attack_kind (attack_kind),
        .attacking   (attacking),
        .cooldown    (cooldown)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [1:0] ml, input logic [1:0] mr,
                                       input logic [1:0] jp, input logic [1:0] cr,
                                       input logic [1:0] st, input logic [1:0] kd,
                                       input logic [1:0] at, input logic [1:0] cd);
        return {ml, mr, jp, cr, st, kd, at, cd};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] mask, input logic [15:0] exp);
        sb_t e;
        e.tag  = tag;
        e.mask = mask;
        e.exp  = exp & mask;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        sb_t         e;
        logic [15:0] obs;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e   = sb_q.pop_front();
            obs = {move_left, move_right, jump, crouch,
                   attack_start, attack_kind, attacking, cooldown} & e.mask;
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        keycode_a  = 8'h04;
        keycode_b  = 8'h00;

        // Reset and release latency
        step(3);
        expect_out("reset_all_zero", M_ALL, 16'h0000); check_out();
        rst = 1'b0;
        step(1);
        expect_out("release_edge1", M_ALL, 16'h0000); check_out();
        step(1);
        expect_out("release_left", M_ALL, mk(2'b01, 0, 0, 0, 0, 0, 0, 0)); check_out();

        // Movement conflicts
        keycode_b = 8'h07;
        step(2);
        expect_out("left_right_conflict", M_ALL, 16'h0000); check_out();
        keycode_a = 8'h1A; keycode_b = 8'h16;
        step(2);
        expect_out("jump_crouch_conflict", M_ALL, mk(0, 0, 2'b01, 0, 0, 0, 0, 0)); check_out();
        keycode_a = 8'h50; keycode_b = 8'h52;
        step(2);
        expect_out("p2_left_jump", M_ALL, mk(2'b10, 0, 2'b10, 0, 0, 0, 0, 0)); check_out();
        keycode_a = 8'h00; keycode_b = 8'h00;
        step(2);

        // P1 punch with default timing
        keycode_a = 8'h09;
        step(1);
        expect_out("punch_edge1", M_ALL, 16'h0000); check_out();
        step(1);
        expect_out("punch_start", M_ALL, mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 0)); check_out();
        step(1);
        expect_out("punch_pulse_1cyc", M_ALL, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 0)); check_out();
        step(20);
        expect_out("no_tick_holds", M_ALL, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 0)); check_out();
        tick(7);
        expect_out("active_7_ticks", M_ALL, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 0)); check_out();
        tick(1);
        expect_out("cooldown_entry", M_NOKIND, mk(0, 0, 0, 0, 0, 0, 0, 2'b01)); check_out();
        tick(3);
        expect_out("cooldown_3_ticks", M_NOKIND, mk(0, 0, 0, 0, 0, 0, 0, 2'b01)); check_out();
        tick(1);
        expect_out("back_to_idle", M_NOKIND, 16'h0000); check_out();
        step(3);
        expect_out("held_no_retrigger", M_NOKIND, 16'h0000); check_out();
        keycode_a = 8'h00;
        step(2);
        keycode_a = 8'h09;
        step(2);
        expect_out("repress_start", M_ALL, mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 0)); check_out();
        tick(12);
        keycode_a = 8'h00;
        step(2);

        // Simultaneous punch/kick, then concurrent P2 kick
        keycode_a = 8'h09; keycode_b = 8'h0A;
        step(2);
        expect_out("punch_wins", M_ALL, mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 0)); check_out();
        keycode_b = 8'h0E;
        step(2);
        expect_out("p2_kick_concurrent", M_ALL, mk(0, 0, 0, 0, 2'b10, 2'b10, 2'b11, 0)); check_out();
        tick(8);
        expect_out("both_cooldown", M_NOKIND, mk(0, 0, 0, 0, 0, 0, 0, 2'b11)); check_out();
        tick(4);
        expect_out("both_idle", M_NOKIND, 16'h0000); check_out();
        keycode_a = 8'h00; keycode_b = 8'h00;
        step(2);

        // Discard during ACTIVE/COOLDOWN and movement masking
        keycode_a = 8'h09;
        step(2);
        expect_out("mask_start", M_NOKIND, mk(0, 0, 0, 0, 2'b01, 0, 2'b01, 0)); check_out();
        keycode_a = 8'h00;
        step(2);
        keycode_a = 8'h09;
        step(2);
        expect_out("discard_in_active", M_NOKIND, mk(0, 0, 0, 0, 0, 0, 2'b01, 0)); check_out();
        keycode_a = 8'h04;
        step(2);
        expect_out("left_masked_active", M_NOKIND, mk(0, 0, 0, 0, 0, 0, 2'b01, 0)); check_out();
        tick(8);
        expect_out("left_in_cooldown", M_NOKIND, mk(2'b01, 0, 0, 0, 0, 0, 0, 2'b01)); check_out();
        keycode_b = 8'h09;
        step(2);
        expect_out("discard_in_cooldown", M_NOKIND, mk(2'b01, 0, 0, 0, 0, 0, 0, 2'b01)); check_out();
        tick(4);
        expect_out("idle_after_discard", M_NOKIND, mk(2'b01, 0, 0, 0, 0, 0, 0, 0)); check_out();
        step(2);
        expect_out("held_on_idle_entry", M_NOKIND, mk(2'b01, 0, 0, 0, 0, 0, 0, 0)); check_out();
        keycode_a = 8'h00; keycode_b = 8'h00;
        step(2);

        // Reset in the middle of ACTIVE
        keycode_a = 8'h09;
        step(2);
        expect_out("pre_reset_start", M_NOKIND, mk(0, 0, 0, 0, 2'b01, 0, 2'b01, 0)); check_out();
        tick(5);
        keycode_a = 8'h00;
        rst = 1'b1;
        step(1);
        expect_out("reset_mid_active", M_ALL, 16'h0000); check_out();
        rst = 1'b0;
        step(2);
        expect_out("post_reset_idle", M_ALL, 16'h0000); check_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
